// File: rtl/pim_chunk_addr_gen_pkg.sv
// Shared types and default geometry for the PIM chunk address generator.
// Modules import this package and override the geometry through their own parameters.
package pim_chunk_addr_gen_pkg;

  localparam int unsigned PIM_ROWS        = 2;
  localparam int unsigned PIM_COLS        = 2;
  localparam int unsigned MAX_MATRIX_SIZE = 8;
  localparam int unsigned MEM_ELEMENTS    = 1024;
  localparam int unsigned LEN             = $clog2(MEM_ELEMENTS);
  localparam int unsigned SZ_W            = $clog2(MAX_MATRIX_SIZE + 1);
  localparam int unsigned UNIT_W          = (PIM_ROWS * PIM_COLS > 1) ?
                                            $clog2(PIM_ROWS * PIM_COLS) : 1;

  typedef enum logic [1:0] {
    PimIdle  = 2'd0,
    PimCheck = 2'd1,
    PimRun   = 2'd2,
    PimDone  = 2'd3
  } pim_state_e;

  typedef struct packed {
    logic [LEN-1:0]    addr;
    logic [UNIT_W-1:0] unit;
    logic [SZ_W-1:0]   row;
    logic [SZ_W-1:0]   col;
    logic              chunk_last;
    logic              last;
  } pim_beat_t;

endpackage

// File: rtl/pim_chunk_counter.sv
// Nested j/i/unit counters with a row-base address accumulator.
// Addresses are built from additions of the row stride and chunk width only.
module pim_chunk_counter
  import pim_chunk_addr_gen_pkg::*;
#(
  parameter int unsigned PIM_ROWS = pim_chunk_addr_gen_pkg::PIM_ROWS,
  parameter int unsigned PIM_COLS = pim_chunk_addr_gen_pkg::PIM_COLS,
  parameter int unsigned LEN      = pim_chunk_addr_gen_pkg::LEN,
  parameter int unsigned SZ_W     = pim_chunk_addr_gen_pkg::SZ_W,
  parameter int unsigned UNIT_W   = pim_chunk_addr_gen_pkg::UNIT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_i,
  input  logic              advance_i,
  input  logic [LEN-1:0]    base_i,
  input  logic [LEN-1:0]    n_i,
  input  logic [LEN-1:0]    cc_i,
  input  logic [SZ_W-1:0]   cr_m1_i,
  input  logic [SZ_W-1:0]   cc_m1_i,
  output logic [SZ_W-1:0]   row_o,
  output logic [SZ_W-1:0]   col_o,
  output logic [UNIT_W-1:0] unit_o,
  output logic [LEN-1:0]    addr_o,
  output logic              j_wrap_o,
  output logic              i_wrap_o,
  output logic              unit_wrap_o
);

  localparam int unsigned NUnits  = PIM_ROWS * PIM_COLS;
  localparam int unsigned ColMask = PIM_COLS - 1;

  logic [SZ_W-1:0]   i_q, i_d, j_q, j_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [LEN-1:0]    row_base_q, row_base_d;
  logic [LEN-1:0]    unit_base_q, unit_base_d;
  logic [LEN-1:0]    next_unit_base;
  logic              col_wrap;

  assign j_wrap_o    = (j_q == cc_m1_i);
  assign i_wrap_o    = (i_q == cr_m1_i);
  assign unit_wrap_o = (unit_q == UNIT_W'(NUnits - 1));
  assign col_wrap    = ((unit_q & UNIT_W'(ColMask)) == UNIT_W'(ColMask));

  // Past the last grid column the next unit starts one row below the last row of this chunk.
  assign next_unit_base = (col_wrap ? row_base_q : unit_base_q) + cc_i;

  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    unit_d      = unit_q;
    row_base_d  = row_base_q;
    unit_base_d = unit_base_q;
    if (init_i) begin
      i_d         = '0;
      j_d         = '0;
      unit_d      = '0;
      row_base_d  = base_i;
      unit_base_d = base_i;
    end else if (advance_i) begin
      if (!j_wrap_o) begin
        j_d = j_q + SZ_W'(1);
      end else begin
        j_d = '0;
        if (!i_wrap_o) begin
          i_d        = i_q + SZ_W'(1);
          row_base_d = row_base_q + n_i;
        end else begin
          i_d         = '0;
          unit_d      = unit_wrap_o ? '0 : unit_q + UNIT_W'(1);
          row_base_d  = next_unit_base;
          unit_base_d = next_unit_base;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q         <= '0;
      j_q         <= '0;
      unit_q      <= '0;
      row_base_q  <= '0;
      unit_base_q <= '0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      unit_q      <= unit_d;
      row_base_q  <= row_base_d;
      unit_base_q <= unit_base_d;
    end
  end

  assign row_o  = i_q;
  assign col_o  = j_q;
  assign unit_o = unit_q;
  assign addr_o = row_base_q + LEN'(j_q);

endmodule

// File: rtl/pim_chunk_addr_gen.sv
// Scatters one runtime-sized square matrix across a PIM_ROWS x PIM_COLS grid of PIM units,
// emitting one address beat per handshake with configuration checking and abort.
module pim_chunk_addr_gen
  import pim_chunk_addr_gen_pkg::*;
#(
  parameter int unsigned PIM_ROWS        = pim_chunk_addr_gen_pkg::PIM_ROWS,
  parameter int unsigned PIM_COLS        = pim_chunk_addr_gen_pkg::PIM_COLS,
  parameter int unsigned MAX_MATRIX_SIZE = pim_chunk_addr_gen_pkg::MAX_MATRIX_SIZE,
  parameter int unsigned MEM_ELEMENTS    = pim_chunk_addr_gen_pkg::MEM_ELEMENTS,
  parameter int unsigned LEN             = $clog2(MEM_ELEMENTS),
  parameter int unsigned SZ_W            = $clog2(MAX_MATRIX_SIZE + 1),
  parameter int unsigned UNIT_W          = (PIM_ROWS * PIM_COLS > 1) ?
                                           $clog2(PIM_ROWS * PIM_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN-1:0]    base_addr,
  input  logic [SZ_W-1:0]   matrix_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN-1:0]    out_addr,
  output logic [UNIT_W-1:0] out_unit,
  output logic [SZ_W-1:0]   out_row,
  output logic [SZ_W-1:0]   out_col,
  output logic              out_chunk_last,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] StIdle  = 2'(PimIdle);
  localparam logic [1:0] StCheck = 2'(PimCheck);
  localparam logic [1:0] StRun   = 2'(PimRun);
  localparam logic [1:0] StDone  = 2'(PimDone);

  localparam int unsigned RowShift = $clog2(PIM_ROWS);
  localparam int unsigned ColShift = $clog2(PIM_COLS);
  localparam int unsigned EndW     = LEN + 2 * SZ_W;

  logic [1:0]        state_q, state_d;
  logic [LEN-1:0]    base_q;
  logic [SZ_W-1:0]   n_q;
  logic              err_q, err_d;
  logic              cfg_load, cfg_ok;
  logic [EndW-1:0]   span_end;
  logic [SZ_W-1:0]   cr, cc;
  logic              running, advance;
  logic [SZ_W-1:0]   row, col;
  logic [UNIT_W-1:0] unit;
  logic [LEN-1:0]    addr;
  logic              j_wrap, i_wrap, unit_wrap, chunk_last;

  assign cfg_load = (state_q == StIdle) && start;
  assign cr       = n_q >> RowShift;
  assign cc       = n_q >> ColShift;

  // One past the last touched word; full width so a large base cannot wrap into range.
  assign span_end = EndW'(base_q) + EndW'(n_q) * EndW'(n_q);
  assign cfg_ok   = (n_q != '0) &&
                    (n_q <= SZ_W'(MAX_MATRIX_SIZE)) &&
                    ((n_q & SZ_W'(PIM_ROWS - 1)) == '0) &&
                    ((n_q & SZ_W'(PIM_COLS - 1)) == '0) &&
                    (span_end <= EndW'(MEM_ELEMENTS));

  assign running = (state_q == StRun);
  assign advance = running && out_ready && !abort;

  pim_chunk_counter #(
    .PIM_ROWS (PIM_ROWS),
    .PIM_COLS (PIM_COLS),
    .LEN      (LEN),
    .SZ_W     (SZ_W),
    .UNIT_W   (UNIT_W)
  ) u_counter (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_i      (state_q == StCheck),
    .advance_i   (advance),
    .base_i      (base_q),
    .n_i         (LEN'(n_q)),
    .cc_i        (LEN'(cc)),
    .cr_m1_i     (cr - SZ_W'(1)),
    .cc_m1_i     (cc - SZ_W'(1)),
    .row_o       (row),
    .col_o       (col),
    .unit_o      (unit),
    .addr_o      (addr),
    .j_wrap_o    (j_wrap),
    .i_wrap_o    (i_wrap),
    .unit_wrap_o (unit_wrap)
  );

  assign chunk_last = i_wrap && j_wrap;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: begin
        state_d = cfg_ok ? StRun : StIdle;
        err_d   = !cfg_ok;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (advance && chunk_last && unit_wrap) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      base_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cfg_load) begin
        base_q <= base_addr;
        n_q    <= matrix_size;
      end
    end
  end

  // Beat fields are forced to zero outside RUN so idle and reset outputs are clean.
  assign out_valid      = running;
  assign out_addr       = running ? addr : '0;
  assign out_unit       = running ? unit : '0;
  assign out_row        = running ? row : '0;
  assign out_col        = running ? col : '0;
  assign out_chunk_last = running && chunk_last;
  assign out_last       = running && chunk_last && unit_wrap;
  assign busy           = (state_q == StCheck) || running;
  assign done           = (state_q == StDone);
  assign err            = err_q;

endmodule
